// File: rtl/std_cache_pkg.sv
// Shared data-cache types: SRAM request bundle, line/byte-enable types,
// requester ID width and the arbiter FSM state encoding.
package std_cache_pkg;

  localparam int unsigned DCACHE_SET_ASSOC   = 4;
  localparam int unsigned DCACHE_INDEX_WIDTH = 8;
  localparam int unsigned DCACHE_TAG_WIDTH   = 8;
  localparam int unsigned DCACHE_LINE_WIDTH  = 64;
  // Requester IDs: 0 = snoop, 1..NR_PORTS = core ports (up to 7 cores).
  localparam int unsigned ARB_ID_W           = 3;

  typedef logic [DCACHE_LINE_WIDTH-1:0]   cache_line_t;
  typedef logic [DCACHE_LINE_WIDTH/8-1:0] cl_be_t;

  typedef struct packed {
    logic [DCACHE_SET_ASSOC-1:0]   req;
    logic                          lock;
    logic [DCACHE_INDEX_WIDTH-1:0] addr;
    logic [DCACHE_TAG_WIDTH-1:0]   tag;
    logic                          we;
    cl_be_t                        be;
    cache_line_t                   data;
  } sram_req_t;

  typedef enum logic [1:0] {
    ARB,
    HOLD,
    LOCKED
  } arb_state_e;

endpackage

// File: rtl/dcache_rr_sel.sv
// Round-robin search: first active core port at or after ptr_i, wrapping.
module dcache_rr_sel
  import std_cache_pkg::*;
#(
  parameter int unsigned NR_PORTS = 3
) (
  input  logic [NR_PORTS-1:0] active_i,
  input  logic [ARB_ID_W-1:0] ptr_i,
  output logic                found_o,
  output logic [ARB_ID_W-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    // Upper segment [ptr..NR_PORTS-1] first, then the wrapped lower segment.
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      if (!found_o && active_i[i] && (i >= 32'(ptr_i))) begin
        found_o = 1'b1;
        idx_o   = ARB_ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      if (!found_o && active_i[i] && (i < 32'(ptr_i))) begin
        found_o = 1'b1;
        idx_o   = ARB_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/dcache_sram_arbiter.sv
// Arbitrates the shared data-cache SRAM between the snoop controller and
// NR_PORTS core controllers, with hold-until-grant, locking and snoop bursts.
module dcache_sram_arbiter
  import std_cache_pkg::*;
#(
  parameter int unsigned NR_PORTS        = 3,
  parameter int unsigned SNOOP_BURST_MAX = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  sram_req_t                       snoop_req_i,
  output logic                            snoop_gnt_o,
  output logic                            snoop_rvalid_o,
  input  sram_req_t [NR_PORTS-1:0]        core_req_i,
  output logic [NR_PORTS-1:0]             core_gnt_o,
  output logic [NR_PORTS-1:0]             core_rvalid_o,
  output logic [DCACHE_SET_ASSOC-1:0]     req_o,
  output logic [DCACHE_INDEX_WIDTH-1:0]   addr_o,
  output logic [DCACHE_TAG_WIDTH-1:0]     tag_o,
  output logic                            we_o,
  output cl_be_t                          be_o,
  output cache_line_t                     data_o,
  input  logic                            gnt_i
);

  localparam int unsigned CNT_W = $clog2(SNOOP_BURST_MAX + 1);
  typedef logic [ARB_ID_W-1:0] id_t;

  arb_state_e                    state_q, state_d;
  id_t                           sel_q, sel_d, id_q, id_d, rr_q, rr_d;
  logic [CNT_W-1:0]              starve_q, starve_d;
  logic [DCACHE_TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                          rvalid_q, rvalid_d;

  sram_req_t [NR_PORTS:0]        all_req;
  logic [NR_PORTS:0]             all_act;
  logic                          any_core, rr_found, arb_valid, sel_valid, sel_act, grant;
  id_t                           rr_idx, sel_id;
  sram_req_t                     sel_req;

  assign all_req  = {core_req_i, snoop_req_i};
  assign any_core = |all_act[NR_PORTS:1];

  always_comb begin
    all_act = '0;
    for (int unsigned i = 0; i <= NR_PORTS; i++) all_act[i] = |all_req[i].req;
  end

  dcache_rr_sel #(.NR_PORTS(NR_PORTS)) u_rr_sel (
    .active_i (all_act[NR_PORTS:1]),
    .ptr_i    (rr_q),
    .found_o  (rr_found),
    .idx_o    (rr_idx)
  );

  always_comb begin
    sel_id    = '0;
    arb_valid = 1'b0;
    unique case (state_q)
      ARB: begin
        if (all_act[0] && ((starve_q < CNT_W'(SNOOP_BURST_MAX)) || !any_core)) begin
          arb_valid = 1'b1;
        end else if (rr_found) begin
          arb_valid = 1'b1;
          sel_id    = id_t'(rr_idx + id_t'(1));
        end
      end
      HOLD: begin
        arb_valid = 1'b1;
        sel_id    = sel_q;
      end
      LOCKED: sel_id = sel_q;
      default: ;
    endcase
  end

  always_comb begin
    sel_req = '0;
    sel_act = 1'b0;
    for (int unsigned i = 0; i <= NR_PORTS; i++) begin
      if (sel_id == id_t'(i)) begin
        sel_req = all_req[i];
        sel_act = all_act[i];
      end
    end
  end

  // Gating with rst_ni keeps the SRAM and grants quiet while reset is held.
  assign sel_valid = rst_ni && ((state_q == LOCKED) ? sel_act : arb_valid);
  assign grant     = sel_valid && gnt_i;

  assign req_o  = sel_valid ? sel_req.req  : '0;
  assign addr_o = sel_valid ? sel_req.addr : '0;
  assign we_o   = sel_valid && sel_req.we;
  assign be_o   = sel_valid ? sel_req.be   : '0;
  assign data_o = sel_valid ? sel_req.data : '0;
  assign tag_o  = tag_q;

  assign snoop_gnt_o    = grant && (sel_id == '0);
  assign snoop_rvalid_o = rvalid_q && (id_q == '0);
  always_comb begin
    core_gnt_o    = '0;
    core_rvalid_o = '0;
    for (int unsigned k = 0; k < NR_PORTS; k++) begin
      core_gnt_o[k]    = grant && (sel_id == id_t'(k + 1));
      core_rvalid_o[k] = rvalid_q && (id_q == id_t'(k + 1));
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    id_d     = id_q;
    rr_d     = rr_q;
    starve_d = starve_q;
    tag_d    = tag_q;
    rvalid_d = grant && !sel_req.we;

    if (state_q == LOCKED) begin
      if (!sel_req.lock) state_d = ARB;
    end else if (grant) begin
      state_d = sel_req.lock ? LOCKED : ARB;
      sel_d   = sel_id;
    end else if (sel_valid) begin
      state_d = HOLD;
      sel_d   = sel_id;
    end else begin
      state_d = ARB;
    end

    if (grant) begin
      id_d  = sel_id;
      tag_d = sel_req.tag;
      if (sel_id != '0) rr_d = (sel_id == id_t'(NR_PORTS)) ? '0 : sel_id;
    end

    if (!any_core || (grant && (sel_id != '0))) begin
      starve_d = '0;
    end else if (grant && (starve_q < CNT_W'(SNOOP_BURST_MAX))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB;
      sel_q    <= '0;
      id_q     <= '0;
      rr_q     <= '0;
      starve_q <= '0;
      tag_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      id_q     <= id_d;
      rr_q     <= rr_d;
      starve_q <= starve_d;
      tag_q    <= tag_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_dcache_sram_arbiter.sv
// Directed scoreboard bench for dcache_sram_arbiter (3 cores, burst limit 4).
module tb_dcache_sram_arbiter;
  import std_cache_pkg::*;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  sram_req_t                     snoop_req;
  sram_req_t [2:0]               core_req;
  logic                          snoop_gnt, snoop_rvalid, we_o, gnt_i;
  logic [2:0]                    core_gnt, core_rvalid;
  logic [DCACHE_SET_ASSOC-1:0]   req_o;
  logic [DCACHE_INDEX_WIDTH-1:0] addr_o;
  logic [DCACHE_TAG_WIDTH-1:0]   tag_o;
  cl_be_t                        be_o;
  cache_line_t                   data_o;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] r;
    logic [3:0] v;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_sram_arbiter #(.NR_PORTS(3), .SNOOP_BURST_MAX(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .snoop_req_i    (snoop_req),
    .snoop_gnt_o    (snoop_gnt),
    .snoop_rvalid_o (snoop_rvalid),
    .core_req_i     (core_req),
    .core_gnt_o     (core_gnt),
    .core_rvalid_o  (core_rvalid),
    .req_o          (req_o),
    .addr_o         (addr_o),
    .tag_o          (tag_o),
    .we_o           (we_o),
    .be_o           (be_o),
    .data_o         (data_o),
    .gnt_i          (gnt_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // id 0 = snoop, id k+1 = core k; way vector is one-hot so req_o identifies the source.
  task automatic set_req(input int id, input bit on, input bit lk, input bit w, input logic [7:0] t);
    sram_req_t r;
    r = '0;
    if (on) begin
      r.req  = 4'b0001 << id;
      r.lock = lk;
      r.we   = w;
      r.tag  = t;
      r.addr = 8'(id * 16 + 1);
      r.be   = '1;
      r.data = {8{8'(id)}};
    end
    if (id == 0) snoop_req = r;
    else core_req[id-1] = r;
  endtask

  task automatic clear_all();
    snoop_req = '0;
    core_req  = '0;
  endtask

  // Push the expectation for this cycle, sample at the falling edge, step to the next drive point.
  task automatic exp_cycle(input string tag, input logic [3:0] g, input logic [3:0] r, input logic [3:0] v);
    exp_t e;
    sb.push_back('{g: g, r: r, v: v});
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, ".gnt"}, {core_gnt, snoop_gnt}, e.g);
    chk({tag, ".req_o"}, req_o, e.r);
    chk({tag, ".rvalid"}, {core_rvalid, snoop_rvalid}, e.v);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit keep);
    rst_n = 1'b0;
    if (!keep) clear_all();
    @(negedge clk);
    chk("rst.gnt", {core_gnt, snoop_gnt}, 4'b0000);
    chk("rst.rvalid", {core_rvalid, snoop_rvalid}, 4'b0000);
    chk("rst.req_o", req_o, 4'b0000);
    chk("rst.we_o", we_o, 1'b0);
    chk("rst.addr_o", addr_o, 8'h00);
    chk("rst.tag_o", tag_o, 8'h00);
    clear_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    gnt_i = 1'b1;
    clear_all();
    do_reset(1'b0);

    // Snoop burst of four, then the starving core gets in.
    set_req(0, 1, 0, 0, 8'h05);
    set_req(1, 1, 0, 0, 8'h10);
    for (int i = 0; i < 4; i++) exp_cycle("burst", 4'b0001, 4'b0001, (i == 0) ? 4'b0000 : 4'b0001);
    exp_cycle("burst.core0", 4'b0010, 4'b0010, 4'b0001);
    clear_all();
    exp_cycle("burst.idle", 4'b0000, 4'b0000, 4'b0010);

    do_reset(1'b0);

    // Round robin across all three cores.
    set_req(1, 1, 0, 0, 8'h11);
    set_req(2, 1, 0, 0, 8'h12);
    set_req(3, 1, 0, 0, 8'h13);
    exp_cycle("rr.0", 4'b0010, 4'b0010, 4'b0000);
    exp_cycle("rr.1", 4'b0100, 4'b0100, 4'b0010);
    exp_cycle("rr.2", 4'b1000, 4'b1000, 4'b0100);
    exp_cycle("rr.3", 4'b0010, 4'b0010, 4'b1000);
    clear_all();
    exp_cycle("rr.idle", 4'b0000, 4'b0000, 4'b0010);

    // Core1 held while the SRAM stalls; a snoop arriving meanwhile must wait.
    gnt_i = 1'b0;
    set_req(2, 1, 0, 0, 8'h21);
    exp_cycle("hold.1", 4'b0000, 4'b0100, 4'b0000);
    set_req(0, 1, 0, 0, 8'h22);
    exp_cycle("hold.2", 4'b0000, 4'b0100, 4'b0000);
    exp_cycle("hold.3", 4'b0000, 4'b0100, 4'b0000);
    gnt_i = 1'b1;
    exp_cycle("hold.gnt", 4'b0100, 4'b0100, 4'b0000);
    set_req(2, 0, 0, 0, 8'h00);
    exp_cycle("hold.snoop", 4'b0001, 4'b0001, 4'b0100);
    clear_all();
    exp_cycle("hold.idle", 4'b0000, 4'b0000, 4'b0001);

    // Locked snoop keeps exclusive access until lock drops.
    set_req(0, 1, 1, 0, 8'h31);
    set_req(1, 1, 0, 0, 8'h32);
    exp_cycle("lock.1", 4'b0001, 4'b0001, 4'b0000);
    exp_cycle("lock.2", 4'b0001, 4'b0001, 4'b0001);
    exp_cycle("lock.3", 4'b0001, 4'b0001, 4'b0001);
    set_req(0, 1, 0, 0, 8'h31);
    exp_cycle("lock.4", 4'b0001, 4'b0001, 4'b0001);
    set_req(0, 0, 0, 0, 8'h00);
    exp_cycle("lock.core0", 4'b0010, 4'b0010, 4'b0001);
    clear_all();
    exp_cycle("lock.idle", 4'b0000, 4'b0000, 4'b0010);

    // Tag capture and rvalid only after reads.
    set_req(3, 1, 0, 0, 8'h1A);
    exp_cycle("tag.rd", 4'b1000, 4'b1000, 4'b0000);
    clear_all();
    exp_cycle("tag.rd.next", 4'b0000, 4'b0000, 4'b1000);
    chk("tag.rd.tag_o", tag_o, 8'h1A);
    set_req(3, 1, 0, 1, 8'h2B);
    exp_cycle("tag.wr", 4'b1000, 4'b1000, 4'b0000);
    clear_all();
    exp_cycle("tag.wr.next", 4'b0000, 4'b0000, 4'b0000);
    chk("tag.wr.tag_o", tag_o, 8'h2B);

    // Reset while locked with a read pending.
    do_reset(1'b0);
    set_req(0, 1, 1, 0, 8'h41);
    set_req(1, 1, 0, 0, 8'h42);
    exp_cycle("midrst.lock", 4'b0001, 4'b0001, 4'b0000);
    do_reset(1'b1);
    set_req(1, 1, 0, 0, 8'h42);
    exp_cycle("midrst.arb", 4'b0010, 4'b0010, 4'b0000);
    clear_all();
    exp_cycle("midrst.idle", 4'b0000, 4'b0000, 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_sram_arbiter.md
DCACHE_SRAM_ARBITER -- requirements
Module: dcache_sram_arbiter

Interface
REQ-001 Parameters: NR_PORTS, 3, number of core cache-controller requesters.
REQ-002 Parameters: SNOOP_BURST_MAX, 4, consecutive snoop grants allowed while a core request waits.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-004 Port: clk_i  input  1  clock.
REQ-005 Port: rst_ni  input  1  asynchronous active-low reset.
REQ-006 Port: snoop_req_i  input  sram_req_t  snoop controller request: req[DCACHE_SET_ASSOC], lock, addr, tag, we, be, data.
REQ-007 Port: snoop_gnt_o  output  1  snoop grant.
REQ-008 Port: snoop_rvalid_o  output  1  read data/hit flags valid for snoop.
REQ-009 Port: core_req_i  input  NR_PORTS x sram_req_t  core requests.
REQ-010 Port: core_gnt_o  output  NR_PORTS  core grants.
REQ-011 Port: core_rvalid_o  output  NR_PORTS  read valid per core port.
REQ-012 Port: req_o  output  DCACHE_SET_ASSOC  SRAM way enables.
REQ-013 Port: addr_o  output  DCACHE_INDEX_WIDTH  SRAM index.
REQ-014 Port: tag_o  output  DCACHE_TAG_WIDTH  compare tag, one cycle after grant.
REQ-015 Port: we_o  output  1  SRAM write enable.
REQ-016 Port: be_o  output  cl_be_t  byte/flag enables.
REQ-017 Port: data_o  output  cache_line_t  write data.
REQ-018 Port: gnt_i  input  1  SRAM grant.

Function
REQ-019 Requester is active when its req vector is non-zero; requesters hold request stable until granted.
REQ-020 Requester IDs: 0 = snoop, 1..NR_PORTS = core ports 0..NR_PORTS-1.
REQ-021 States: ARB (free arbitration), HOLD (selected requester waiting for gnt_i), LOCKED (owner has exclusive access).
REQ-022 ARB: snoop selected if active and (starve_cnt < SNOOP_BURST_MAX or no core active); else first active core at or after rr_ptr, wrapping modulo NR_PORTS.
REQ-023 Selected request forwarded combinationally to req_o/addr_o/we_o/be_o/data_o; its grant = gnt_i in the same cycle; all other grants 0.
REQ-024 Selected with gnt_i=0 -> HOLD; selection frozen in sel_q and forwarded until gnt_i, regardless of new higher-priority requests.
REQ-025 On a grant with lock=1 -> LOCKED, owner = granted ID; otherwise -> ARB.
REQ-026 LOCKED: only owner forwarded/granted; others see gnt 0; owner lock=0 in a cycle -> ARB next cycle, that cycle still exclusive.
REQ-027 starve_cnt: +1 on each snoop grant while any core active, saturates at SNOOP_BURST_MAX; cleared on any core grant or when no core active.
REQ-028 rr_ptr: on core grant of port k, set to (k+1) mod NR_PORTS; unchanged otherwise.
REQ-029 id_q: registered on every grant; tag_o = tag of requester id_q; id_q and tag_o hold otherwise.
REQ-030 rvalid of requester id_q asserted exactly one cycle after its grant with we=0; never after a write.
REQ-031 No active/selected requester: req_o, we_o, be_o, data_o, addr_o all 0.
REQ-032 NR_PORTS=1: round-robin degenerates, rr_ptr stays 0.

Reset
REQ-033 Reset: state ARB, rr_ptr 0, starve_cnt 0, id_q 0, sel_q 0; all grants, rvalids, req_o, we_o 0.
REQ-034 Reset mid-transaction (HOLD/LOCKED, pending rvalid): abandoned, no rvalid after reset release.

Structure
REQ-035 sram_req_t and ID width constant live in std_cache_pkg; cache_line_t, cl_be_t reused from there.
REQ-036 One sub-module, dcache_rr_sel: round-robin first-active search from rr_ptr; FSM, counters, muxing stay in top.

Verification
REQ-037 Snoop and core0 active, gnt_i=1, starve_cnt 0 -> snoop granted cycles 1-4, core0 granted cycle 5, starve_cnt 0.
REQ-038 Core0,1,2 active continuously, no snoop -> grant order 0,1,2,0; rr_ptr 1,2,0,1.
REQ-039 Core1 selected, gnt_i=0 for 3 cycles, snoop rises in cycle 2 -> core1 stays forwarded, granted cycle 4, snoop next.
REQ-040 Snoop granted with lock=1, core0 active, lock drops cycle 4 -> only snoop granted cycles 1-4, core0 granted cycle 5.
REQ-041 Core2 read granted, tag=0x1A -> tag_o=0x1A and core_rvalid_o[2]=1 next cycle; write grant -> no rvalid.
REQ-042 Reset asserted in LOCKED with pending read -> next cycle all outputs 0, state ARB, no rvalid.
